// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer widths, pointer type and Gray-code helpers
// used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

  typedef logic [FIFO_PTR_WIDTH-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[FIFO_PTR_WIDTH-1] = g[FIFO_PTR_WIDTH-1];
    for (int i = FIFO_PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray_to_binary #(
  parameter int PTR_WIDTH = 4
) (
  input  logic [PTR_WIDTH-1:0] i_gray,
  output logic [PTR_WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < PTR_WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[PTR_WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer / FULL controller of the async FIFO. Define AF_FLAG_EN to
// add the registered ALMOST_FULL output (occupancy >= depth - AF_MARGIN).
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int ADDR_WIDTH = FIFO_ADDR_WIDTH,
`ifdef AF_FLAG_EN
  parameter  int AF_MARGIN  = 2,
`endif
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [PTR_WIDTH-1:0]  RQ2_RPTR,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [PTR_WIDTH-1:0]  WQ_PTR,
  output logic                  W_CLKEN,
  output logic                  FULL
`ifdef AF_FLAG_EN
  ,
  output logic                  ALMOST_FULL
`endif
);

  logic [PTR_WIDTH-1:0] r_bin;
  logic [PTR_WIDTH-1:0] r_wq_ptr;
  logic                 r_full;
  logic                 w_accept;
  logic [PTR_WIDTH-1:0] w_bin_next;
  logic [PTR_WIDTH-1:0] w_gray_next;
  logic [PTR_WIDTH-1:0] w_full_ptr;

  assign w_accept    = W_INC & ~r_full;
  assign w_bin_next  = r_bin + {{(PTR_WIDTH-1){1'b0}}, w_accept};
  assign w_gray_next = bin2gray(w_bin_next);

  // Write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign w_full_ptr  = {~RQ2_RPTR[PTR_WIDTH-1:PTR_WIDTH-2], RQ2_RPTR[PTR_WIDTH-3:0]};

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bin    <= '0;
      r_wq_ptr <= '0;
      r_full   <= 1'b0;
    end else begin
      r_bin    <= w_bin_next;
      r_wq_ptr <= w_gray_next;
      r_full   <= (w_gray_next == w_full_ptr);
    end
  end

  assign W_ADDR = r_bin[ADDR_WIDTH-1:0];
  assign WQ_PTR = r_wq_ptr;
  assign FULL   = r_full;

  // NOTE: FULL is 0 during reset, so the enable must be gated by RST itself.
  assign W_CLKEN = w_accept & RST;

`ifdef AF_FLAG_EN
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [PTR_WIDTH-1:0] w_rbin;
  logic [PTR_WIDTH-1:0] w_occ_next;
  logic                 r_almost_full;

  gray_to_binary #(
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rptr_g2b (
    .i_gray (RQ2_RPTR),
    .o_bin  (w_rbin)
  );

  // Modulo subtraction; the wrap bit makes a full FIFO read as DEPTH, not 0.
  assign w_occ_next = w_bin_next - w_rbin;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_occ_next >= PTR_WIDTH'(DEPTH - AF_MARGIN));
    end
  end

  assign ALMOST_FULL = r_almost_full;
`endif

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
Write-side pointer and full-flag controller for the async FIFO between clock domains.
- Sequences write-address generation and registered Gray-coded write-pointer publication.
- The published pointer is the only signal the read domain synchronizes.
- Computes FULL against the read pointer already synchronized into this domain.
- Sits between the write-domain producer (UART/register-file path) and the FIFO memory, next to the 2-FF pointer synchronizers.

Parameters:
ADDR_WIDTH, 3, FIFO address bits; depth = 2**ADDR_WIDTH (8).
PTR_WIDTH, ADDR_WIDTH+1, pointer width incl. wrap bit (4); fixed relation, not overridden independently.
AF_MARGIN, 2, almost-full margin in entries (used only with the optional feature).

Ports:
CLK  in  1  write-domain clock
RST  in  1  asynchronous active-low reset
W_INC  in  1  write request from producer, sampled on rising CLK
RQ2_RPTR  in  PTR_WIDTH  read pointer, Gray, already 2-FF synchronized into CLK domain
W_ADDR  out  ADDR_WIDTH  memory write address = low bits of binary write pointer
WQ_PTR  out  PTR_WIDTH  registered Gray write pointer to read-domain synchronizer
W_CLKEN  out  1  memory write enable = W_INC & ~FULL (combinational)
FULL  out  1  registered full flag
ALMOST_FULL  out  1  registered; present only with AF_FLAG_EN

Behaviour:
- One clock, CLK; reset is asynchronous, active-low on RST.
- RST low: binary pointer = 0; WQ_PTR = 0; FULL = 0; ALMOST_FULL = 0.
  - Takes effect immediately, independent of CLK.
  - W_ADDR = 0 and W_CLKEN = 0 while RST is low.
- Write accept: W_INC=1 and FULL=0 at a rising edge.
  - Memory writes at the current W_ADDR.
  - Binary pointer increments by 1 mod 2**PTR_WIDTH.
- W_INC=1 while FULL=1: ignored. Pointer, WQ_PTR and memory unchanged; no error, no sticky state.
- Next-state signals each cycle:
  - bin_next = bin + (W_INC & ~FULL).
  - gray_next = bin_next ^ (bin_next >> 1).
  - WQ_PTR <= gray_next, so WQ_PTR always equals Gray(binary pointer) with zero extra latency relative to the binary register.
  - Only one WQ_PTR bit changes per accepted write, including wrap 4'b1000 -> 4'b0000.
- FULL <= (gray_next == {~RQ2_RPTR[PTR_WIDTH-1:PTR_WIDTH-2], RQ2_RPTR[PTR_WIDTH-3:0]}).
  - Asserts in the cycle after the accept that fills the FIFO. No combinational path from RQ2_RPTR to FULL.
- FULL deassert latency: one CLK after RQ2_RPTR advances. End-to-end 3 CLKs after the read pointer changes in the read domain, including synchronizers. This pessimism is intended.
- Simultaneous write and read-pointer update in the same cycle:
  - FULL is evaluated on gray_next against the new RQ2_RPTR.
  - Never asserts falsely; at most stays asserted one extra cycle.
- RQ2_RPTR is trusted to be Gray-valid. Non-Gray jumps are not detected.
- No state machine beyond the pointer counter and flag registers.

Optional Feature:
Macro AF_FLAG_EN.
- Defined:
  - rbin = Gray-to-binary(RQ2_RPTR), computed combinationally.
  - occ_next = (bin_next - rbin) mod 2**PTR_WIDTH.
  - ALMOST_FULL <= (occ_next >= 2**ADDR_WIDTH - AF_MARGIN); with defaults, >= 6.
  - ALMOST_FULL is high whenever FULL is high.
  - Reset value 0.
- Undefined: ALMOST_FULL port, subtractor and Gray-to-binary logic are absent. All other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_ADDR_WIDTH = 3 and FIFO_PTR_WIDTH = FIFO_ADDR_WIDTH+1
  - the ptr_t typedef (PTR_WIDTH-bit logic)
  - bin2gray and gray2bin functions, reused by the read-side controller
- One sub-module is natural: gray_to_binary, instantiated only under AF_FLAG_EN.
  - XOR-prefix, parameterized on PTR_WIDTH, no case tables.
  - Binary-to-Gray stays as an inline package function call.

Test Plan:
1. Reset: hold RST=0 with W_INC=1 and CLK toggling 5 cycles -> WQ_PTR=0000, FULL=0, W_CLKEN=0, W_ADDR=000. Release RST -> first write at W_ADDR=000.
2. Fill: RQ2_RPTR=0000, W_INC=1 for 10 cycles -> W_ADDR 0..7, WQ_PTR sequence 0001,0011,0010,0110,0111,0101,0100,1100. FULL=1 after 8th accept; writes 9-10 have W_CLKEN=0 and WQ_PTR held at 1100.
3. Release: from full state, RQ2_RPTR -> 0001 -> FULL=0 one CLK later. Next W_INC accepted at W_ADDR=000, WQ_PTR=1101.
4. Wrap: RQ2_RPTR tracks WQ_PTR with 2-cycle lag for 20 writes -> FULL never asserts. WQ_PTR passes 1000 -> 0000; every step differs by exactly one bit.
5. Mid-operation reset: after 5 writes (WQ_PTR=0111), pulse RST low between clock edges -> outputs 0 immediately, not at the next edge. Resumes at W_ADDR=000.
6. AF_FLAG_EN: RQ2_RPTR=0000, 6 writes -> ALMOST_FULL=1 after 6th accept, 0 after 5th. Set RQ2_RPTR=0011 (rbin=2) -> ALMOST_FULL=0 next cycle.
